video_collision_unit: RTL
=========================

# video_collision_unit

Pixel-stream consumer that sits directly downstream of the tile/sprite video stage. Each pixel clock it samples the per-sprite opaque-pixel flags and the background-nonzero flag that the compositor uses for its colour mux. It accumulates sprite-sprite and sprite-background collisions over one frame and latches them at each frame boundary. The CPU reads the latched results over the iomem bus at 0x0540_0000, and can optionally take an end-of-frame interrupt.

## Interface
- NUM_SPRITES, 8, number of sprite hit lanes; 1..8 supported, status fields zero-padded to 8 bits
- clk  in  1  pixel/system clock, shared with the video stage
- reset  in  1  asynchronous, active-high; clears all state
- iomem_valid  in  1  bus request
- iomem_ready  out  1  one-cycle acknowledge
- iomem_wstrb  in  4  byte write strobes; 0 = read
- iomem_addr  in  32  byte address; block selected when [23:20]==4'h4
- iomem_wdata  in  32  write data
- iomem_rdata  out  32  read data, valid while iomem_ready=1, else 0
- video_active  in  1  visible-pixel qualifier from sync generator
- vga_vsync  in  1  active-low vertical sync from sync generator
- pix_sprite_hit  in  NUM_SPRITES  bit i = sprite i draws an opaque pixel this cycle
- pix_bg_nonzero  in  1  background texel is nonzero this cycle
- irq  out  1  end-of-frame collision interrupt, level

## Operation
- Accumulation applies only on cycles with video_active=1:
  - if popcount(pix_sprite_hit) ≥ 2: work_ss |= pix_sprite_hit
  - if pix_bg_nonzero=1: work_sb |= pix_sprite_hit
- Frame boundary is vsync_d=1 && vga_vsync=0, where vsync_d is a 1-cycle delay of vga_vsync that resets to 1. On that edge:
  - lat_ss ← work_ss, lat_sb ← work_sb
  - work_ss and work_sb ← 0
  - frame_cnt ← frame_cnt+1, 16-bit, wraps 0xFFFF→0x0000
  - pending ← 1 if (work_ss|work_sb)≠0
- Register map (offset = iomem_addr[3:2]):
  - 0: read-only; [7:0] lat_ss, [15:8] lat_sb, [31:16] 0
  - 1: read-only; [15:0] frame_cnt, [31:16] 0
  - 2: control; bit0 irq_en (RW), bit1 pending (read; write 1 clears); other bits read 0
  - 3: reads 0, writes ignored
- Byte strobes: only wstrb[0] is meaningful for control; other strobes are ignored.
- Reads never clear state.
- Bus FSM:
  - IDLE: valid && selected && !ready → ACK. rdata is registered this edge. A write takes effect this edge.
  - ACK: ready=1 for exactly one cycle → IDLE. A request held high re-acknowledges only after returning to IDLE, so consecutive acks are ≥2 cycles apart.
- Unselected requests are ignored; ready stays 0.
- irq is registered: irq ← pending && irq_en.

## Timing
- Reset values:
  - iomem_ready=0, iomem_rdata=0, irq=0
  - work_*=0, lat_*=0, frame_cnt=0, irq_en=0, pending=0, bus FSM=IDLE
- Reset is asynchronous and may arrive mid-frame or mid-transaction. The FSM returns to IDLE, and the first frame edge after release latches only pixels seen after release.
- Bus read latency is 1 cycle: request edge → ready+rdata on the next cycle.
- A read issued on the frame-edge cycle returns the pre-edge latched values.
- Hit inputs are sampled on the rising edge. A collision pixel at cycle N appears in work at N+1.
- The frame boundary updates latches at edge E. irq rises at E+1 when enabled.
- A W1C of pending on the same edge that a frame sets pending: set wins, pending=1.
- Writing irq_en=1 while pending=1 makes irq rise on the next cycle.
- A pixel with video_active=1 on the frame-edge cycle accumulates into the new work, not into the latch.

## Configuration
- COLLISION_IRQ_EN defined: control register and irq behave as above.
- COLLISION_IRQ_EN undefined:
  - irq tied to 0
  - offset 2 reads 0; writes to it are acknowledged but ignored
  - pending and irq_en logic not built
- Status and frame counter behaviour are identical in both builds.

## Test plan
- Reset mid-frame with hits active → all outputs 0. After next vsync fall, offset 0 reads 0x0000_0000 and offset 1 reads 0x0000_0001.
- During active video, pix_sprite_hit=0x05 for 1 cycle, then 0x02 with pix_bg_nonzero=1 → after vsync fall, offset 0 reads 0x0000_0205.
- pix_sprite_hit=0x10 with pix_bg_nonzero=1 while video_active=0 → latched 0.
- 65536 frames → frame_cnt reads 0x0000 (wrap).
- COLLISION_IRQ_EN defined: write 0x1 to offset 2, produce a collision frame → irq=1 one cycle after the edge. Write 0x2 on the next frame-edge cycle → pending stays 1. Write 0x2 mid-frame → irq=0 after 1 cycle.
- Bus protocol: valid held high for 6 cycles on a read → ready pulses at cycles 2, 4, 6, each lasting one cycle with correct rdata. A request to 0x0550_0000 → no ready.

Source files
------------

// File: rtl/video_collision_unit_if.sv
// iomem bus bundle for video_collision_unit: the CPU side is the master,
// the collision unit is the slave.
interface video_collision_unit_if;
   logic        iomem_valid;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic [31:0] iomem_rdata;

   modport master (
      output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
      input  iomem_ready, iomem_rdata
   );

   modport slave (
      input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
      output iomem_ready, iomem_rdata
   );
endinterface

// File: rtl/video_collision_unit.sv
// Per-frame sprite/sprite and sprite/background collision latch with an iomem
// register window. Optional end-of-frame interrupt built when COLLISION_IRQ_EN is defined.
module video_collision_unit #(
   parameter int NUM_SPRITES = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   video_collision_unit_if.slave   bus,
   input  logic                    video_active,
   input  logic                    vga_vsync,
   input  logic [NUM_SPRITES-1:0]  pix_sprite_hit,
   input  logic                    pix_bg_nonzero,
   output logic                    irq
);

   typedef enum logic {
      S_IDLE,
      S_ACK
   } bus_state_e;

   logic [NUM_SPRITES-1:0] work_ss_q, work_ss_d;
   logic [NUM_SPRITES-1:0] work_sb_q, work_sb_d;
   logic [NUM_SPRITES-1:0] lat_ss_q, lat_sb_q;
   logic [15:0]            frame_cnt_q;
   logic                   vsync_d_q;
   logic                   frame_edge;
   logic                   multi_hit;

   bus_state_e             state_q;
   logic                   ready_q;
   logic [31:0]            rdata_q;
   logic                   accept;
   logic [1:0]             offset;
   logic [31:0]            rd_mux;
   logic [7:0]             lat_ss8, lat_sb8;

   assign frame_edge = vsync_d_q & ~vga_vsync;
   // Two or more lanes set: clearing the lowest set bit still leaves something.
   assign multi_hit  = |(pix_sprite_hit & (pix_sprite_hit - NUM_SPRITES'(1)));
   assign offset     = bus.iomem_addr[3:2];
   assign accept     = (state_q == S_IDLE) && bus.iomem_valid && !ready_q &&
                       (bus.iomem_addr[23:20] == 4'h4);

`ifdef COLLISION_IRQ_EN
   logic irq_en_q, pending_q, irq_q;
   logic ctrl_wr, work_nonzero;
   logic unused_bits;

   assign ctrl_wr      = accept && bus.iomem_wstrb[0] && (offset == 2'd2);
   assign work_nonzero = |{work_ss_q, work_sb_q};
   assign unused_bits  = ^{bus.iomem_addr[31:24], bus.iomem_addr[19:4], bus.iomem_addr[1:0],
                           bus.iomem_wstrb[3:1], bus.iomem_wdata[31:2]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_en_q  <= 1'b0;
         pending_q <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         if (ctrl_wr) irq_en_q <= bus.iomem_wdata[0];
         // A frame that sets pending beats a same-edge write-1-to-clear.
         if (frame_edge && work_nonzero)          pending_q <= 1'b1;
         else if (ctrl_wr && bus.iomem_wdata[1])  pending_q <= 1'b0;
         irq_q <= pending_q & irq_en_q;
      end
   end

   assign irq = irq_q;
`else
   logic unused_bits;

   assign unused_bits = ^{bus.iomem_addr[31:24], bus.iomem_addr[19:4], bus.iomem_addr[1:0],
                          bus.iomem_wstrb, bus.iomem_wdata};
   assign irq = 1'b0;
`endif

   // A pixel on the frame-edge cycle lands in the freshly cleared work set.
   always_comb begin
      work_ss_d = frame_edge ? '0 : work_ss_q;
      work_sb_d = frame_edge ? '0 : work_sb_q;
      if (video_active) begin
         if (multi_hit)      work_ss_d = work_ss_d | pix_sprite_hit;
         if (pix_bg_nonzero) work_sb_d = work_sb_d | pix_sprite_hit;
      end
   end

   // NOTE: every always_comb output gets a default before the case, so no path infers a latch.
   always_comb begin
      lat_ss8                    = '0;
      lat_sb8                    = '0;
      lat_ss8[NUM_SPRITES-1:0]   = lat_ss_q;
      lat_sb8[NUM_SPRITES-1:0]   = lat_sb_q;
      rd_mux                     = '0;
      case (offset)
         2'd0:    rd_mux = {16'h0000, lat_sb8, lat_ss8};
         2'd1:    rd_mux = {16'h0000, frame_cnt_q};
`ifdef COLLISION_IRQ_EN
         2'd2:    rd_mux = {30'h0, pending_q, irq_en_q};
`endif
         default: rd_mux = '0;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vsync_d_q   <= 1'b1;
         work_ss_q   <= '0;
         work_sb_q   <= '0;
         lat_ss_q    <= '0;
         lat_sb_q    <= '0;
         frame_cnt_q <= '0;
      end else begin
         vsync_d_q <= vga_vsync;
         work_ss_q <= work_ss_d;
         work_sb_q <= work_sb_d;
         if (frame_edge) begin
            lat_ss_q    <= work_ss_q;
            lat_sb_q    <= work_sb_q;
            frame_cnt_q <= frame_cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         ready_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  state_q <= S_ACK;
                  ready_q <= 1'b1;
                  rdata_q <= rd_mux;
               end
            end
            S_ACK: begin
               state_q <= S_IDLE;
               ready_q <= 1'b0;
               rdata_q <= '0;
            end
         endcase
      end
   end

   assign bus.iomem_ready = ready_q;
   assign bus.iomem_rdata = rdata_q;

endmodule
